// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage feeding the decode stage.
//
// Holds the fetch PC and a word-addressed instruction memory. Each unstalled
// cycle it registers the instruction at PC, along with its address and the
// link value (address + 4). Downstream can hold the stage (Stall) or steer it
// to a new target (Redirect). A redirect normally squashes the wrong-path
// instruction fetched in the same cycle.
//
// Configuration macro:
//   BRANCH_DELAY_SLOT_EN - when defined, a redirect does not squash. The
//                          instruction fetched in the redirect cycle (the
//                          delay slot) is delivered as a valid instruction.
//
// Parameters:
//   IMEM_AW   - instruction memory address width in words (depth 2**IMEM_AW)
//   RESET_PC  - word-aligned PC loaded by reset
//
// Ports:
//   CLK, RST            - clock; synchronous active-high reset
//   Stall               - hold PC and all outputs this cycle
//   Redirect/RedirectPC - load a new fetch target; this overrides Stall
//   ImemWe/Waddr/Wdata  - loader write port. It is honoured in every cycle,
//                         including reset.
//   Ins/InsPC/NextPC    - registered instruction, its address, and address + 4
//   InsValid            - 1 = real instruction, 0 = bubble
//   PC                  - address currently being fetched
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [31:0]        RedirectPC,
  input  logic               ImemWe,
  input  logic [IMEM_AW-1:0] ImemWaddr,
  input  logic [31:0]        ImemWdata,
  output logic [31:0]        Ins,
  output logic [31:0]        InsPC,
  output logic [31:0]        NextPC,
  output logic               InsValid,
  output logic [31:0]        PC
);

  logic [31:0]        imem [2**IMEM_AW];
  logic [31:0]        pc_q;
  logic [31:0]        ins_q;
  logic [31:0]        ins_pc_q;
  logic [31:0]        next_pc_q;
  logic               ins_valid_q;

  logic [31:0]        pc_d;
  logic [31:0]        ins_d;
  logic [31:0]        ins_pc_d;
  logic [31:0]        next_pc_d;
  logic               ins_valid_d;

  logic [IMEM_AW-1:0] rd_idx;
  logic [31:0]        fetch_word;
  logic [31:0]        pc_plus4;
  logic               unused_redirect_lsbs;

  // Upper PC bits are dropped, so fetch addresses wrap modulo the memory size.
  assign rd_idx               = pc_q[IMEM_AW+1:2];
  assign fetch_word           = imem[rd_idx];
  assign pc_plus4             = pc_q + 32'd4;
  assign unused_redirect_lsbs = ^RedirectPC[1:0];

  // Loader write port. The read above samples the old word in the same cycle
  // (read-first), because the array only updates at the clock edge.
  always_ff @(posedge CLK) begin
    if (ImemWe) begin
      imem[ImemWaddr] <= ImemWdata;
    end
  end

  // Next-state selection: Redirect > Stall > advance. Reset is applied in
  // the register block below.
  always_comb begin
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_pc_d    = ins_pc_q;
    next_pc_d   = next_pc_q;
    ins_valid_d = ins_valid_q;
    if (Redirect) begin
      pc_d = {RedirectPC[31:2], 2'b00};
`ifdef BRANCH_DELAY_SLOT_EN
      // The delay-slot instruction is delivered normally.
      ins_d       = fetch_word;
      ins_pc_d    = pc_q;
      next_pc_d   = pc_plus4;
      ins_valid_d = 1'b1;
`else
      // Squash the wrong-path fetch into an all-zero NOP bubble.
      ins_d       = 32'h0000_0000;
      ins_pc_d    = 32'h0000_0000;
      next_pc_d   = 32'h0000_0000;
      ins_valid_d = 1'b0;
`endif
    end else if (Stall) begin
      pc_d        = pc_q;
      ins_d       = ins_q;
      ins_pc_d    = ins_pc_q;
      next_pc_d   = next_pc_q;
      ins_valid_d = ins_valid_q;
    end else begin
      pc_d        = pc_plus4;
      ins_d       = fetch_word;
      ins_pc_d    = pc_q;
      next_pc_d   = pc_plus4;
      ins_valid_d = 1'b1;
    end
  end

  // PC and output registers. Synchronous reset overrides Stall and Redirect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q        <= RESET_PC;
      ins_q       <= 32'h0000_0000;
      ins_pc_q    <= 32'h0000_0000;
      next_pc_q   <= 32'h0000_0000;
      ins_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      next_pc_q   <= next_pc_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  assign Ins      = ins_q;
  assign InsPC    = ins_pc_q;
  assign NextPC   = next_pc_q;
  assign InsValid = ins_valid_q;
  assign PC       = pc_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage and supplies its Ins input.
- Holds the program counter and a word-addressed instruction memory with a synchronous read.
- Registers each fetched instruction together with its PC and PC+4. Decode uses PC+4 as the JAL/JALR link value on Wdata.
- Accepts stall requests and PC redirects (branch/jump targets) from downstream. A redirect squashes the wrong-path instruction.

Parameters:
IMEM_AW, 8, instruction memory address width in words (depth = 2**IMEM_AW).
RESET_PC, 32'h0000_0000, PC loaded by reset; must be word-aligned.

Ports:
CLK  input  1  clock; all state updates on posedge CLK.
RST  input  1  reset, synchronous, active-high.
Stall  input  1  hold PC and all outputs this cycle.
Redirect  input  1  load RedirectPC; overrides Stall.
RedirectPC  input  32  branch/jump target; bits [1:0] ignored.
ImemWe  input  1  loader write enable for instruction memory.
ImemWaddr  input  IMEM_AW  loader word address.
ImemWdata  input  32  loader write data.
Ins  output  32  registered instruction to decode.
InsPC  output  32  address of Ins.
NextPC  output  32  InsPC + 4 (link value).
InsValid  output  1  Ins is a real instruction; 0 = bubble.
PC  output  32  address currently being fetched.

Behaviour:
- State: pc_q (fetch address, driven on PC), output registers Ins/InsPC/NextPC/InsValid, and memory array imem[2**IMEM_AW].
- Memory index is pc_q[IMEM_AW+1:2]. Upper PC bits are ignored, so addresses wrap modulo the memory size.
- Reset (RST=1 at posedge):
  - pc_q <= RESET_PC.
  - Ins, InsPC, NextPC <= 0.
  - InsValid <= 0.
  - Reset overrides Stall and Redirect. ImemWe writes are still performed during reset, so a program can be loaded while RST is held.
- Priority each cycle: RST > Redirect > Stall > normal advance.
- Normal advance (no RST, Redirect or Stall):
  - Ins <= imem[pc_q]; InsPC <= pc_q; NextPC <= pc_q + 4; InsValid <= 1.
  - pc_q <= pc_q + 4, with 32-bit wrap from 32'hFFFF_FFFC to 0.
- Latency: an address on PC at cycle N appears on Ins at cycle N+1. The first valid instruction after RST deasserts is imem[RESET_PC], one cycle after release. Throughput is one instruction per unstalled cycle.
- Stall=1, Redirect=0: pc_q and all output registers hold their values. The instruction on Ins stays presented to decode.
- Redirect=1 (Stall ignored):
  - pc_q <= {RedirectPC[31:2], 2'b00}.
  - The instruction being fetched this cycle is squashed: Ins <= 0 (sll $0 NOP), InsValid <= 0, InsPC/NextPC <= 0.
  - The target instruction appears the following cycle.
- Back-to-back Redirects: each one applies and the bubble persists. Redirect during reset is ignored.
- Loader write: if ImemWe=1, imem[ImemWaddr] <= ImemWdata at the posedge. The write happens even when Stall or Redirect is active.
- Read-during-write to the same word is read-first: Ins receives the old contents, and the new word is visible from the next fetch.
- No combinational path from any input to any output.

Optional Feature:
Macro BRANCH_DELAY_SLOT_EN.
- Defined: a Redirect does not squash. The instruction fetched in the redirect cycle (the delay slot) is delivered normally: Ins <= imem[pc_q], InsValid <= 1, InsPC <= pc_q, NextPC <= pc_q + 4. pc_q still loads RedirectPC.
- Not defined: squash as described under Behaviour.
- The Stall, reset and loader rules are identical in both builds.

Test Plan:
- Reset/sequential: load imem[0..3] = 32'h2009000A, 32'h200A0008, 32'h012A5820, 32'hAC0B0000, release RST. Required, one cycle after release: Ins = 32'h2009000A, InsPC = 0, NextPC = 4, InsValid = 1. The next three cycles give InsPC = 4, 8, 12 in order. Throughout reset: InsValid = 0 and Ins = 0.
- Stall: assert Stall for 3 cycles while Ins = 32'h200A0008 and PC = 8. Required: Ins, InsPC = 4, NextPC = 8 and PC = 8 are unchanged for all 3 cycles. After release, Ins = 32'h012A5820 follows.
- Redirect with squash (macro off): at PC = 8, pulse Redirect with RedirectPC = 32'h0000_0043. Required next cycle: PC = 32'h40, InsValid = 0, Ins = 0. The following cycle: InsPC = 32'h40, InsValid = 1.
- Redirect + Stall same cycle: Stall = 1, Redirect = 1, RedirectPC = 32'h10. Required: the redirect takes effect and PC = 32'h10 next cycle.
- Delay slot (BRANCH_DELAY_SLOT_EN defined): same stimulus as the redirect test. Required: the cycle after Redirect gives Ins = imem[2], InsPC = 8, InsValid = 1, then InsPC = 32'h40.
- Wrap and read-first: IMEM_AW = 8, Redirect to 32'h0000_03FC. Required: Ins = imem[255], then InsPC = 32'h400 with Ins = imem[0]. Writing imem[5] in the same cycle PC = 20 returns the old word on Ins.
